// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte per request and drives the pins through open-drain pull-low enables.
//
// Ports:
//   clk, reset                  system clock, async active-high reset
//   tx_data, tx_valid, tx_ready command byte handshake (accept = valid & ready)
//   ps2_clk_in, ps2_data_in     raw pin levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe     1 = pull the pad low, 0 = release
//   busy                        high whenever a frame is in progress
//   done                        one-cycle pulse at frame end
//   ack_ok, timeout             frame status, valid with done, held until next accept
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    STOP_IDX = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_e;

  state_e        state_q;
  logic [10:0]   frame_q;
  logic [3:0]    idx_q;
  logic [CW-1:0] cnt_q;

  logic clk_oe_q;
  logic data_oe_q;
  logic ready_q;
  logic busy_q;
  logic done_q;
  logic ack_q;
  logic to_q;

  logic clk_s1_q;
  logic clk_s2_q;
  logic clk_prev_q;
  logic dat_s1_q;
  logic dat_s2_q;

  logic          fall_d;
  logic [CW-1:0] cnt_inc_d;
  logic [3:0]    idx_inc_d;
  logic          to_hit_d;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_d    = clk_prev_q & ~clk_s2_q;
  assign cnt_inc_d = cnt_q + 1'b1;
  assign idx_inc_d = idx_q + 1'b1;

  // The device clock watchdog only runs while waiting on device edges.
  assign to_hit_d = ((state_q == S_SEND) || (state_q == S_ACK))
                  && !fall_d && (cnt_inc_d == TO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (to_hit_d) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        to_q      <= 1'b1;
        ack_q     <= 1'b0;
        done_q    <= 1'b1;
        ready_q   <= 1'b1;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
        state_q   <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (tx_valid && ready_q) begin
              // Bit 0 start, 1..8 data, 9 odd parity, 10 stop.
              frame_q  <= {1'b1, ~^tx_data, tx_data, 1'b0};
              ack_q    <= 1'b0;
              to_q     <= 1'b0;
              cnt_q    <= '0;
              clk_oe_q <= 1'b1;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
              cnt_q     <= '0;
              data_oe_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_REQ: begin
            if (cnt_q == SET_LAST) begin
              cnt_q     <= '0;
              idx_q     <= '0;
              clk_oe_q  <= 1'b0;
              data_oe_q <= ~frame_q[0];
              state_q   <= S_SEND;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_SEND: begin
            if (fall_d) begin
              // Present the next bit right after the device falling edge.
              idx_q     <= idx_inc_d;
              cnt_q     <= '0;
              data_oe_q <= ~frame_q[idx_inc_d];
              if (idx_inc_d == STOP_IDX) begin
                state_q <= S_ACK;
              end
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_ACK: begin
            if (fall_d) begin
              ack_q   <= ~dat_s2_q;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_WAIT: begin
            if (clk_s2_q && dat_s2_q) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: testbench for ps2_host_tx.
// Uses a PS/2 device model on the open-drain bus and checks frames against the protocol rules.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int SET = 8;
  localparam int TO  = 600;
  localparam int HP  = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .timeout    (timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int t_clk_rise = 0;
  int t_clk_fall = 0;
  int t_dat_rise = 0;
  logic p_clk = 1'b0;
  logic p_dat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_clk_oe && !p_clk) t_clk_rise <= cyc;
    if (!ps2_clk_oe && p_clk) t_clk_fall <= cyc;
    if (ps2_data_oe && !p_dat && ps2_clk_oe) t_dat_rise <= cyc;
    p_clk <= ps2_clk_oe;
    p_dat <= ps2_data_oe;
    if (done) done_cnt <= done_cnt + 1;
    if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Line levels a correct host must present, from the frame rules.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_cmd(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (ps2_clk_in && !ps2_data_in) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic dev_frame(input bit do_ack, output logic [10:0] samp);
    bit ok;
    samp = '0;
    wait_start(ok);
    chk("start_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      repeat (10) @(posedge clk);
      samp[0] = ps2_data_in;
      for (int k = 1; k <= 10; k++) begin
        dev_clk_low = 1'b1;
        repeat (HP) @(posedge clk);
        dev_clk_low = 1'b0;
        samp[k] = ps2_data_in;
        repeat (HP) @(posedge clk);
      end
      if (do_ack) dev_data_low = 1'b1;
      repeat (5) @(posedge clk);
      dev_clk_low = 1'b1;
      repeat (HP) @(posedge clk);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] d,
                             input bit ack, input bit exp_par);
    logic [10:0] samp;
    bit ok;
    int dc;
    dc = done_cnt;
    send_cmd(d);
    chk({name, "_rdy_drop"}, {31'd0, tx_ready}, 32'd0);
    chk({name, "_clk_oe"}, {31'd0, ps2_clk_oe}, 32'd1);
    dev_frame(ack, samp);
    chk({name, "_bits"}, {21'd0, samp}, {21'd0, model_frame(d)});
    chk({name, "_par"}, {31'd0, samp[9]}, {31'd0, exp_par});
    wait_done(300, ok);
    chk({name, "_done"}, {31'd0, ok}, 32'd1);
    chk({name, "_ack"}, {31'd0, ack_ok}, {31'd0, ack});
    chk({name, "_to"}, {31'd0, timeout}, 32'd0);
    @(negedge clk);
    chk({name, "_ndone"}, done_cnt - dc, 32'd1);
    chk({name, "_idle"}, {30'd0, tx_ready, busy}, 32'd2);
  endtask

  initial begin
    logic [10:0] samp;
    logic [7:0]  rd;
    bit          ra;
    bit          ok;
    int          tf;
    int          ab;

    vecs[0] = '{data: 8'hED, ack: 1'b1, exp_par: 1'b1};
    vecs[1] = '{data: 8'h01, ack: 1'b1, exp_par: 1'b0};
    vecs[2] = '{data: 8'h00, ack: 1'b0, exp_par: 1'b1};
    vecs[3] = '{data: 8'hFF, ack: 1'b1, exp_par: 1'b1};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("rst_rdy_busy", {30'd0, tx_ready, busy}, 32'd2);
    chk("rst_status", {29'd0, done, ack_ok, timeout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      check_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack,
                  vecs[i].exp_par);
      if (i == 0) begin
        chk("inhibit_len", t_dat_rise - t_clk_rise, INH);
        chk("setup_len", t_clk_fall - t_dat_rise, SET);
      end
    end

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      ra = 1'($urandom);
      check_frame($sformatf("rnd%0d", i), rd, ra,
                  ($countones(rd) % 2 == 0));
    end

    // Dead device: no clock after the request phase.
    send_cmd(8'h5A);
    tf = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe) begin
        tf = cyc;
        break;
      end
    end
    chk("dead_clk_rel", {31'd0, tf >= 0}, 32'd1);
    wait_done(TO + 50, ok);
    chk("dead_done", {31'd0, ok}, 32'd1);
    chk("dead_time", cyc - tf, TO);
    chk("dead_status", {30'd0, timeout, ack_ok}, 32'd2);
    chk("dead_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("dead_rdy", {31'd0, tx_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Reset while bit index 5 is on the wire.
    send_cmd(8'hAA);
    wait_start(ok);
    chk("mid_start", {31'd0, ok}, 32'd1);
    repeat (10) @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(posedge clk);
      dev_clk_low = 1'b0;
      repeat (HP) @(posedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_pre_oe", {31'd0, ps2_data_oe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("mid_rst_rdy", {31'd0, tx_ready}, 32'd1);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("after_rst", 8'hFF, 1'b1, 1'b1);

    // Held request during a frame is only taken in the done cycle.
    send_cmd(8'hF4);
    ab = acc_cnt;
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    dev_frame(1'b1, samp);
    chk("hs_f4_bits", {21'd0, samp}, {21'd0, model_frame(8'hF4)});
    wait_done(300, ok);
    chk("hs_done", {31'd0, ok}, 32'd1);
    chk("hs_done_rdy", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("hs_acc_once", acc_cnt - ab, 32'd1);
    chk("hs_busy_again", {30'd0, busy, tx_ready}, 32'd2);
    chk("hs_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    dev_frame(1'b1, samp);
    chk("hs_12_bits", {21'd0, samp}, {21'd0, model_frame(8'h12)});
    wait_done(300, ok);
    chk("hs_12_done", {31'd0, ok}, 32'd1);
    chk("hs_12_ack", {31'd0, ack_ok}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
